// File: rtl/video_line_packer_if.sv
// -----------------------------------------------------------------------------
// video_line_packer_if
// Incoming luminance video stream for the line packer.
//   vs_i : vertical sync, active high; a rising edge starts a frame
//   de_i : data enable, high during the active pixels of a line
//   y_i  : pixel luminance, valid while de_i = 1
// Modports: master = video source, slave = video_line_packer.
// -----------------------------------------------------------------------------
interface video_line_packer_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  vs_i;
    logic                  de_i;
    logic [DATA_WIDTH-1:0] y_i;

    modport master (output vs_i, de_i, y_i);
    modport slave  (input  vs_i, de_i, y_i);
endinterface

// File: rtl/video_line_packer.sv
// -----------------------------------------------------------------------------
// video_line_packer
// Crops a W x H window from the incoming luminance stream, thresholds each
// pixel to 1 bit (1 = white, y >= threshold) and packs each window row into a
// W-bit vector. Publishes the current and previous rows plus the row index
// with a one-cycle strobe, feeding the downstream stroke/crossing counter.
// Ports:
//   video_clk : pixel clock
//   rst_n     : asynchronous active-low reset
//   vid       : video stream (vs_i, de_i, y_i), slave modport
//   thresh    : binarization threshold, latched at each frame start
//   line1     : most recent packed window row, bit k = column X0+k
//   line2     : row packed before line1, zero for window row 0
//   h         : window row index of line1
//   line_clk  : one-cycle strobe, line1/line2/h change only on this cycle
// -----------------------------------------------------------------------------
module video_line_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int W          = 180,
    parameter int H          = 240,
    parameter int X0         = 0,
    parameter int Y0         = 0
) (
    input  logic                  video_clk,
    input  logic                  rst_n,
    video_line_packer_if.slave    vid,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic [W-1:0]          line1,
    output logic [W-1:0]          line2,
    output logic [DATA_WIDTH-1:0] h,
    output logic                  line_clk
);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_DE,
        ACTIVE
    } state_t;

    localparam logic [10:0] X0_C   = 11'(X0);
    localparam logic [10:0] Y0_C   = 11'(Y0);
    localparam logic [10:0] W_C    = 11'(W);
    localparam logic [10:0] H_C    = 11'(H);
    localparam logic [10:0] Y_LAST = 11'(Y0 + H - 1);

    state_t                state, state_next;
    logic                  vs_q;
    logic                  vs_rise;
    logic [10:0]           col_cnt;
    logic [10:0]           row_cnt;
    logic [DATA_WIDTH-1:0] thresh_q;
    logic [W-1:0]          shadow, shadow_next;

    logic                  line_start;
    logic                  line_end;
    logic                  in_window;
    logic                  last_row;
    logic                  capture;
    logic                  white;
    logic [10:0]           cur_col;
    logic [10:0]           col_off;
    logic [10:0]           row_off;

    assign vs_rise = vid.vs_i & ~vs_q;

    // Offsets wrap when below the window origin, so a single unsigned
    // compare against the window size covers both window bounds.
    assign row_off   = row_cnt - Y0_C;
    assign in_window = (row_off < H_C);
    assign last_row  = (row_cnt == Y_LAST);

    // The first pixel of a line is sampled in WAIT_DE, before col_cnt has
    // been restarted, so it is forced to column 0 here.
    assign cur_col = line_start ? 11'd0 : col_cnt;
    assign col_off = cur_col - X0_C;
    assign capture = (line_start || (state == ACTIVE && vid.de_i && !vs_rise))
                     && (col_off < W_C);
    assign white   = (vid.y_i >= thresh_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        line_start = 1'b0;
        line_end   = 1'b0;
        if (vs_rise) begin
            state_next = WAIT_DE;
        end else begin
            case (state)
                WAIT_VS: state_next = WAIT_VS;
                WAIT_DE: begin
                    if (vid.de_i) begin
                        state_next = ACTIVE;
                        line_start = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!vid.de_i) begin
                        line_end   = 1'b1;
                        state_next = (in_window && last_row) ? WAIT_VS : WAIT_DE;
                    end
                end
                default: state_next = WAIT_VS;
            endcase
        end
    end

    // Shadow row: cleared at line start so unreached columns read black.
    always_comb begin
        shadow_next = line_start ? '0 : shadow;
        for (int k = 0; k < W; k++) begin
            if (capture && (col_off == 11'(k))) begin
                shadow_next[k] = white;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= WAIT_VS;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        // NOTE: the wide shadow row is plain flops, not a RAM, so it is reset
        // along with everything else; outputs then read zero straight away.
        if (!rst_n) begin
            vs_q     <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            thresh_q <= '0;
            shadow   <= '0;
            line1    <= '0;
            line2    <= '0;
            h        <= '0;
            line_clk <= 1'b0;
        end else begin
            vs_q     <= vid.vs_i;
            shadow   <= shadow_next;
            line_clk <= 1'b0;
            if (vs_rise) begin
                // Frame start: line1, h are left alone; line2 history clears.
                thresh_q <= thresh;
                row_cnt  <= '0;
                col_cnt  <= '0;
                line2    <= '0;
            end else begin
                if (line_start) begin
                    col_cnt <= 11'd1;
                end else if (state == ACTIVE && vid.de_i && col_cnt != '1) begin
                    col_cnt <= col_cnt + 11'd1;
                end
                if (line_end) begin
                    if (row_cnt != '1) begin
                        row_cnt <= row_cnt + 11'd1;
                    end
                    if (in_window) begin
                        line2    <= (row_off == '0) ? '0 : line1;
                        line1    <= shadow;
                        h        <= DATA_WIDTH'(row_off);
                        line_clk <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_line_packer.sv
// -----------------------------------------------------------------------------
// tb_video_line_packer
// Directed bench for video_line_packer: a table of single-line vectors plus
// hand-written sequences for full frame, threshold latching, cropping, abort
// and asynchronous reset. A second instance with X0 = 10 covers cropping.
// -----------------------------------------------------------------------------
module tb_video_line_packer;

    localparam int DW = 8;
    localparam int W  = 180;
    localparam int H  = 240;

    logic          video_clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] thresh;

    logic [W-1:0]  line1, line2, line1_x, line2_x;
    logic [DW-1:0] h, h_x;
    logic          line_clk, line_clk_x;

    video_line_packer_if #(.DATA_WIDTH(DW)) vid ();

    video_line_packer #(
        .DATA_WIDTH(DW), .W(W), .H(H), .X0(0), .Y0(0)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .vid(vid), .thresh(thresh),
        .line1(line1), .line2(line2), .h(h), .line_clk(line_clk)
    );

    video_line_packer #(
        .DATA_WIDTH(DW), .W(W), .H(H), .X0(10), .Y0(0)
    ) dut_x (
        .video_clk(video_clk), .rst_n(rst_n), .vid(vid), .thresh(thresh),
        .line1(line1_x), .line2(line2_x), .h(h_x), .line_clk(line_clk_x)
    );

    always #5 video_clk = ~video_clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe monitor: counts strobes and back-to-back strobes.
    int   n_strobe = 0;
    int   n_consec = 0;
    logic prev_lc  = 1'b0;
    always @(negedge video_clk) begin
        if (line_clk === 1'b1) begin
            n_strobe++;
            if (prev_lc === 1'b1) n_consec++;
        end
        prev_lc = line_clk;
    end

    // Watchdog: the stimulus is fixed-length, this only guards a stuck run.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Snapshot of outputs taken one step after the strobe edge.
    logic          got, got_x, after_lc;
    logic [W-1:0]  s_l1, s_l2, s_l1x;
    logic [DW-1:0] s_h, s_hx;

    task automatic vs_pulse();
        @(negedge video_clk); vid.vs_i = 1'b1;
        @(negedge video_clk); vid.vs_i = 1'b0;
        repeat (2) @(negedge video_clk);
    endtask

    // Drives one line; mod3 selects "ya on every third pixel" instead of a
    // split at column 'split'. Samples outputs at the edge that sees de=0.
    task automatic drive_line(input int npix, input int split, input logic [DW-1:0] ya,
                              input logic [DW-1:0] yb, input bit mod3);
        for (int i = 0; i < npix; i++) begin
            @(negedge video_clk);
            vid.de_i = 1'b1;
            if (mod3) vid.y_i = (i % 3 == 0) ? ya : yb;
            else      vid.y_i = (i < split) ? ya : yb;
        end
        @(negedge video_clk);
        vid.de_i = 1'b0;
        vid.y_i  = '0;
        @(posedge video_clk); #1;
        got   = line_clk;   s_l1  = line1;   s_l2 = line2; s_h = h;
        got_x = line_clk_x; s_l1x = line1_x; s_hx = h_x;
        @(posedge video_clk); #1;
        after_lc = line_clk;
        repeat (6) @(negedge video_clk);
    endtask

    typedef struct {
        logic [DW-1:0] thr;
        logic [DW-1:0] ya;
        logic [DW-1:0] yb;
        int            split;
        int            npix;
        logic          exp_a;
        logic          exp_b;
    } vec_t;

    vec_t          vecs[5];
    logic [W-1:0]  exp_l1, prev_exp, ones;
    int            base;

    initial begin
        ones = '1;
        // thr, ya, yb, split, npix, expected bit for ya, expected bit for yb
        vecs[0] = '{8'd128, 8'd200, 8'd10,  90,  200, 1'b1, 1'b0};
        vecs[1] = '{8'd128, 8'd128, 8'd127, 50,  180, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   8'd255, 10,  180, 1'b1, 1'b1};
        vecs[3] = '{8'd255, 8'd254, 8'd255, 100, 180, 1'b0, 1'b1};
        vecs[4] = '{8'd128, 8'd255, 8'd255, 60,  60,  1'b1, 1'b1};

        rst_n    = 1'b0;
        thresh   = '0;
        vid.vs_i = 1'b0;
        vid.de_i = 1'b0;
        vid.y_i  = '0;
        #1;
        check("reset line1", line1, '0);
        check("reset line2", line2, '0);
        check("reset h", W'(h), '0);
        check("reset line_clk", W'(line_clk), '0);
        repeat (3) @(negedge video_clk);
        rst_n = 1'b1;

        // Lines before any vs edge must not strobe.
        base = n_strobe;
        drive_line(200, 200, 8'd255, 8'd255, 1'b0);
        check("no vs yet strobe", W'(got), '0);
        check("no vs yet count", W'(n_strobe - base), '0);

        // Table-driven single-line vectors, each in a fresh frame.
        foreach (vecs[v]) begin
            thresh = vecs[v].thr;
            vs_pulse();
            drive_line(vecs[v].npix, vecs[v].split, vecs[v].ya, vecs[v].yb, 1'b0);
            for (int k = 0; k < W; k++)
                exp_l1[k] = (k >= vecs[v].npix) ? 1'b0 :
                            (k < vecs[v].split) ? vecs[v].exp_a : vecs[v].exp_b;
            check($sformatf("vec%0d strobe", v), W'(got), W'(1));
            check($sformatf("vec%0d line1", v), s_l1, exp_l1);
            check($sformatf("vec%0d line2", v), s_l2, '0);
            check($sformatf("vec%0d h", v), W'(s_h), '0);
            check($sformatf("vec%0d strobe width", v), W'(after_lc), '0);
        end

        // Threshold is latched at frame start.
        thresh = 8'd128;
        vs_pulse();
        drive_line(180, 180, 8'd128, 8'd128, 1'b0);
        check("latch row0 line1", s_l1, ones);
        thresh = 8'd200;
        drive_line(180, 180, 8'd150, 8'd150, 1'b0);
        check("latch row1 line1", s_l1, ones);
        check("latch row1 line2", s_l2, ones);
        check("latch row1 h", W'(s_h), W'(1));
        vs_pulse();
        drive_line(180, 180, 8'd150, 8'd150, 1'b0);
        check("relatch line1", s_l1, '0);
        check("relatch h", W'(s_h), '0);

        // Short line and cropping: every third pixel white, 100 pixels.
        thresh = 8'd128;
        vs_pulse();
        drive_line(100, 0, 8'd255, 8'd0, 1'b1);
        for (int k = 0; k < W; k++) exp_l1[k] = (k < 90) && ((k + 10) % 3 == 0);
        check("crop strobe", W'(got_x), W'(1));
        check("crop line1", s_l1x, exp_l1);
        check("crop h", W'(s_hx), '0);
        for (int k = 0; k < W; k++) exp_l1[k] = (k < 100) && (k % 3 == 0);
        check("short line1", s_l1, exp_l1);

        // Full frame: 260 lines, odd rows white.
        thresh = 8'd128;
        vs_pulse();
        base     = n_strobe;
        prev_exp = '0;
        for (int r = 0; r < 260; r++) begin
            drive_line(200, 200, (r % 2 == 1) ? 8'd255 : 8'd0, 8'd0, 1'b0);
            if (r < H) begin
                exp_l1 = (r % 2 == 1) ? ones : '0;
                check($sformatf("frame r%0d strobe", r), W'(got), W'(1));
                check($sformatf("frame r%0d h", r), W'(s_h), W'(r));
                check($sformatf("frame r%0d line1", r), s_l1, exp_l1);
                check($sformatf("frame r%0d line2", r), s_l2, prev_exp);
                prev_exp = exp_l1;
            end else begin
                check($sformatf("frame r%0d no strobe", r), W'(got), '0);
            end
        end
        check("frame strobe count", W'(n_strobe - base), W'(H));

        // Abort: vs rises mid-line together with de falling.
        vs_pulse();
        drive_line(180, 180, 8'd255, 8'd255, 1'b0);
        check("abort pre line1", s_l1, ones);
        base = n_strobe;
        for (int i = 0; i < 50; i++) begin
            @(negedge video_clk); vid.de_i = 1'b1; vid.y_i = 8'd255;
        end
        @(negedge video_clk); vid.de_i = 1'b0; vid.vs_i = 1'b1;
        @(negedge video_clk); vid.vs_i = 1'b0;
        repeat (3) @(negedge video_clk);
        check("abort no strobe", W'(n_strobe - base), '0);
        drive_line(180, 180, 8'd0, 8'd0, 1'b0);
        check("abort next strobe", W'(got), W'(1));
        check("abort next h", W'(s_h), '0);
        check("abort next line2", s_l2, '0);
        check("abort next line1", s_l1, '0);

        // Asynchronous reset mid-line, then no capture until a vs edge.
        vs_pulse();
        drive_line(180, 180, 8'd255, 8'd255, 1'b0);
        check("rst pre line1", s_l1, ones);
        for (int i = 0; i < 40; i++) begin
            @(negedge video_clk); vid.de_i = 1'b1; vid.y_i = 8'd255;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst line1", line1, '0);
        check("async rst line2", line2, '0);
        check("async rst h", W'(h), '0);
        check("async rst line_clk", W'(line_clk), '0);
        @(negedge video_clk); rst_n = 1'b1;
        base = n_strobe;
        for (int i = 0; i < 40; i++) begin
            @(negedge video_clk); vid.de_i = 1'b1; vid.y_i = 8'd255;
        end
        @(negedge video_clk); vid.de_i = 1'b0;
        repeat (4) @(negedge video_clk);
        drive_line(180, 180, 8'd255, 8'd255, 1'b0);
        check("post rst no strobe", W'(n_strobe - base), '0);
        vs_pulse();
        drive_line(180, 180, 8'd255, 8'd255, 1'b0);
        check("post rst vs strobe", W'(got), W'(1));
        check("post rst vs h", W'(s_h), '0);
        check("post rst vs line1", s_l1, ones);

        check("no back-to-back strobes", W'(n_consec), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_line_packer.md
# video_line_packer

Front-end stage of the digit-recognition path. Crops a W×H window out of the incoming 8-bit luminance pixel stream and thresholds each pixel to 1 bit (0 = black, 1 = white). Packs each window row into a W-bit vector and publishes the current row and the previous row, with the row index and a one-cycle line strobe. These outputs directly drive the downstream stroke/crossing counter (`line1`, `line2`, `h`, `line_clk`).

## Interface
- `DATA_WIDTH`, 8: pixel luminance width; also the width of `h`.
- `W`, 180: window width in pixels; width of `line1`/`line2`.
- `H`, 240: window height in rows.
- `X0`, 0: first captured column, counted from the start of `de_i` in each line.
- `Y0`, 0: first captured row, counted from the first `de_i` line after `vs_i` rises.
- `video_clk` in 1: pixel clock, the single clock of the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `vs_i` in 1: vertical sync, active high; its rising edge starts a frame.
- `de_i` in 1: data enable, high during active pixels of a line.
- `y_i` in DATA_WIDTH: pixel luminance, valid when `de_i`=1.
- `thresh` in DATA_WIDTH: binarization threshold.
- `line1` out W: most recent packed window row; bit k = column X0+k.
- `line2` out W: row packed before `line1`; all zeros for the first row of a frame.
- `h` out DATA_WIDTH: window row index of `line1`, 0..H-1.
- `line_clk` out 1: one-cycle strobe; `line1`/`line2`/`h` change only on this cycle.

## Operation
- States:
  - WAIT_VS: after reset, and after H rows of a frame. Ignores `de_i`.
  - WAIT_DE: between lines.
  - ACTIVE: `de_i` high.
- Transitions:
  - WAIT_VS → WAIT_DE on a `vs_i` rising edge.
  - WAIT_DE → ACTIVE on `de_i`=1.
  - ACTIVE → WAIT_DE when `de_i` falls.
  - Any state → WAIT_DE on a `vs_i` rising edge.
- Frame start (`vs_i` rising edge, detected from a registered copy of `vs_i`):
  - `thresh` is latched and used for the whole frame.
  - Row counter cleared; `line2` history cleared to 0.
  - `line1`, `h`, `line_clk` are not modified.
- Column counter: counts `de_i`=1 cycles within a line, 11 bits, saturates at 2047.
- Row counter: counts completed lines, 11 bits, saturates.
- A line is in-window when Y0 ≤ row < Y0+H.
- Pixel capture: when `de_i`=1 and X0 ≤ col < X0+W, the shadow register bit (col−X0) is set to (`y_i` ≥ latched thresh). Equal to the threshold counts as white.
- Shadow register is cleared to 0 at the start of every line. Columns never reached (short line) therefore read as 0 (black).
- End of an in-window line (first edge with `de_i`=0 after 1):
  - `line2` ← `line1`, except on window row 0, where `line2` ← 0.
  - `line1` ← shadow.
  - `h` ← row − Y0.
  - `line_clk` ← 1.
- After window row H-1 is published, go to WAIT_VS. Remaining lines of the frame produce no strobes.
- A `vs_i` rising edge during ACTIVE aborts the line: no strobe, counters reset.
- Lines outside the window update counters only; no strobe.

## Timing
- Reset values: `line1`=0, `line2`=0, `h`=0, `line_clk`=0, state WAIT_VS, latched thresh=0.
- Strobe timing:
  - `line_clk` is high for exactly one cycle, on the first rising edge at which `de_i` is sampled 0 after being 1.
  - `line1`/`line2`/`h` are registered on that same edge, so they are valid while `line_clk`=1 and stable until the next strobe.
- Latency: last active pixel sampled at edge n → strobe and data at edge n+1.
- Strobe spacing equals the video line period (≥ W + blanking), which is enough for the downstream W-cycle scan.
- No strobe is ever issued on two consecutive cycles.
- Asynchronous reset mid-line: outputs return to reset values immediately. Capture resumes only after the next `vs_i` rising edge.
- `h` width: row−Y0 is truncated to DATA_WIDTH bits; H ≤ 2^DATA_WIDTH is a parameter legality rule.

## Test plan
- **Basic strobe and packing.** After reset, one `vs_i` pulse, then a 200-pixel line with `y_i`=200 for cols 0..89 and 10 elsewhere, `thresh`=128 → one `line_clk` one cycle after `de_i` falls. `line1[89:0]` all 1, `line1[179:90]` all 0, `line2`=0, `h`=0.
- **Full frame.** 260 lines of 200 pixels, row r all white if r is odd → exactly 240 strobes with `h`=0..239 in order. On each strobe `line2` equals the previous `line1`. No strobes for rows 240..259.
- **Threshold boundary and latching.** `y_i`=128 with `thresh`=128 → bit = 1. Change `thresh` to 200 mid-frame → bits still use 128 until the next `vs_i` edge.
- **Short line and cropping.** X0=10, line of 100 pixels → `line1[89:0]` follows pixels 10..99, `line1[179:90]`=0.
- **Abort and reset.** `vs_i` rising edge mid-line → no strobe, next line gives `h`=0, `line2`=0. `rst_n` low mid-line → all outputs 0 asynchronously. Lines without a preceding `vs_i` → no strobes.
